key_decoder: RTL and testbench
==============================

Name: key_decoder

Overview:
- Converts the PS/2 keyboard byte stream into the one-hot 4-bit arrow-key command that drives car_ctl.key.
- Tracks make and break codes for the four arrow keys and holds a per-key pressed bitmap.
- Presents the most recently pressed, still-held arrow as `key`.
- Sits between the PS/2 byte receiver (upstream) and car_ctl (downstream), in the pclk domain (65 MHz, 1024x768).

Parameters:
- TIMEOUT_CYCLES, 65000: maximum pclk cycles allowed between bytes of one multi-byte sequence (1 ms at 65 MHz).
- CODE_UP, 8'h75: extended scancode for the Up arrow.
- CODE_DOWN, 8'h72: extended scancode for the Down arrow.
- CODE_LEFT, 8'h6B: extended scancode for the Left arrow.
- CODE_RIGHT, 8'h74: extended scancode for the Right arrow.

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received PS/2 byte; valid only while rx_valid=1.
- rx_valid  in  1  single-cycle strobe, one per received byte; no backpressure.
- key  out  4  one-hot command: 0001 up, 0010 down, 0100 left, 1000 right, 0000 none.
- held  out  4  bitmap of arrows currently pressed, same bit order as key.
- parse_err  out  1  one-cycle pulse on a sequence timeout.

Behaviour:
- Reset (rst=1 at a pclk edge): key=0, held=0, parse_err=0, parser state=IDLE, timeout counter=0, last-pressed register invalid. Reset overrides any in-progress sequence.
- Parser FSM, advancing only on cycles with rx_valid=1:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> IDLE (non-extended make codes ignored).
  - EXT: F0 -> EXT_BRK; arrow code -> set that held bit, record it as last-pressed, go to IDLE; E0 -> EXT; any other byte -> IDLE.
  - BRK: any byte -> IDLE (non-extended release, ignored).
  - EXT_BRK: arrow code -> clear that held bit, go to IDLE; any other byte -> IDLE.
- Timeout:
  - The counter resets to 0 on every rx_valid and increments each cycle while state != IDLE.
  - On reaching TIMEOUT_CYCLES-1 with no byte: state -> IDLE, parse_err=1 for exactly one cycle. held is unchanged.
  - The counter holds at 0 while in IDLE.
- Typematic repeat (a make code for a key already held):
  - held is unchanged.
  - The key is re-recorded as last-pressed, so a repeat of a held key re-selects it.
- Key selection:
  - If last-pressed is valid and its held bit is 1, key = one-hot of last-pressed.
  - Else, if any held bit is 1, key = highest-priority held key (up > down > left > right), and last-pressed is updated to that key.
  - Else key=0 and last-pressed becomes invalid.
  - key is always one-hot or zero, never multi-bit.
- Latency: held and key are registered and update on the pclk edge after the cycle carrying the final byte of a sequence (1-cycle latency). Intermediate bytes (E0, F0) never change key or held.
- Simultaneous events: a make code and a timeout expiry in the same cycle resolve in favour of the byte. The counter resets, no parse_err is raised, and the byte is processed.
- rx_valid strobes on consecutive cycles are each processed, with no minimum gap.

Test Plan:
- Reset, then stream E0,75 -> one cycle after the 75 strobe: held=0001, key=0001; parse_err stays 0.
- E0,75 then E0,6B -> key=0100, held=0101. Then E0,F0,6B -> key=0001, held=0001 (fallback to the still-held Up).
- E0,74 ; E0,72 ; E0,75 (all held), then release Up with E0,F0,75 -> key=0010 (priority fallback: down over right), held=1010.
- Byte 75 without E0, then F0,75 -> held=0000, key=0000 throughout (non-extended codes ignored).
- E0 then no byte for 65000 cycles -> parse_err pulses for exactly one cycle at cycle 64999 after the E0 strobe. A following 75 is then ignored (FSM is in IDLE) and key stays 0000.
- Assert rst for one cycle during EXT_BRK while held=1000 -> held=0000, key=0000. A following 6B is then ignored.

Source files
------------

// File: rtl/key_decoder.sv
// PS/2 scancode parser that tracks make/break of the four extended arrow keys
// and drives a one-hot command of the most recently pressed, still-held arrow.
module key_decoder #(
   parameter int          TIMEOUT_CYCLES = 65000,
   parameter logic [7:0]  CODE_UP        = 8'h75,
   parameter logic [7:0]  CODE_DOWN      = 8'h72,
   parameter logic [7:0]  CODE_LEFT      = 8'h6B,
   parameter logic [7:0]  CODE_RIGHT     = 8'h74
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [3:0] key,
   output logic [3:0] held,
   output logic       parse_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_valid;
   logic [1:0]    last_idx;

   logic       arrow_hit;
   logic [1:0] arrow_idx;
   logic [3:0] held_n;
   logic [3:0] key_n;
   logic       last_valid_n;
   logic [1:0] last_idx_n;
   logic       timeout_hit;

   always_comb begin
      arrow_hit = 1'b1;
      arrow_idx = 2'd0;
      case (rx_data)
         CODE_UP:    arrow_idx = 2'd0;
         CODE_DOWN:  arrow_idx = 2'd1;
         CODE_LEFT:  arrow_idx = 2'd2;
         CODE_RIGHT: arrow_idx = 2'd3;
         default:    arrow_hit = 1'b0;
      endcase
   end

   // Selection uses the post-byte bitmap so key tracks held with the same latency;
   // a released last-pressed key falls back to the fixed priority up>down>left>right.
   always_comb begin
      held_n       = held;
      last_valid_n = last_valid;
      last_idx_n   = last_idx;
      key_n        = 4'b0000;
      if (rx_valid && arrow_hit) begin
         if (state == EXT) begin
            held_n[arrow_idx] = 1'b1;
            last_valid_n      = 1'b1;
            last_idx_n        = arrow_idx;
         end else if (state == EXT_BRK) begin
            held_n[arrow_idx] = 1'b0;
         end
      end
      if (last_valid_n && held_n[last_idx_n]) begin
         key_n = 4'b0001 << last_idx_n;
      end else if (held_n != 4'b0000) begin
         last_valid_n = 1'b1;
         if (held_n[0])      last_idx_n = 2'd0;
         else if (held_n[1]) last_idx_n = 2'd1;
         else if (held_n[2]) last_idx_n = 2'd2;
         else                last_idx_n = 2'd3;
         key_n = 4'b0001 << last_idx_n;
      end else begin
         last_valid_n = 1'b0;
         last_idx_n   = 2'd0;
      end
   end

   assign timeout_hit = !rx_valid && (state != IDLE) && (cnt == CNT_LAST);

   // A byte arriving in the expiry cycle wins: it clears the counter and suppresses the error.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         held       <= 4'b0000;
         key        <= 4'b0000;
         last_valid <= 1'b0;
         last_idx   <= 2'd0;
         parse_err  <= 1'b0;
      end else begin
         held       <= held_n;
         key        <= key_n;
         last_valid <= last_valid_n;
         last_idx   <= last_idx_n;
         parse_err  <= timeout_hit;
         if (rx_valid) begin
            cnt <= '0;
            case (state)
               IDLE: begin
                  if (rx_data == 8'hE0)      state <= EXT;
                  else if (rx_data == 8'hF0) state <= BRK;
                  else                       state <= IDLE;
               end
               EXT: begin
                  if (rx_data == 8'hF0)      state <= EXT_BRK;
                  else if (rx_data == 8'hE0) state <= EXT;
                  else                       state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (timeout_hit) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_key_decoder.sv
// Randomized scoreboard bench for key_decoder: a sequence-prefix reference model
// predicts held/key/parse_err, and a monitor compares whenever the DUT reacts.
module tb_key_decoder;

   localparam int TIMEOUT = 65000;

   typedef struct packed {
      logic [3:0] held;
      logic [3:0] key;
      logic       err;
   } exp_t;

   logic       pclk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] key;
   logic [3:0] held;
   logic       parse_err;

   int checks   = 0;
   int failures = 0;

   exp_t sb[$];
   logic mon_evt = 1'b0;

   logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

   logic [7:0] m_pre[$];
   logic [3:0] m_held;
   logic [3:0] m_key;
   int         m_last;
   int         m_timer;
   logic       m_err;

   key_decoder dut (
      .pclk(pclk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .key(key),
      .held(held),
      .parse_err(parse_err)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic int arrow_of(input logic [7:0] b);
      for (int i = 0; i < 4; i++)
         if (arrows[i] == b) return i;
      return -1;
   endfunction

   // One clock edge of the reference: sequences are tracked as the list of prefix bytes seen so far.
   task automatic model_step(input logic r, input logic v, input logic [7:0] b);
      int a;
      m_err = 1'b0;
      if (r) begin
         m_pre.delete();
         m_held  = 4'b0000;
         m_last  = -1;
         m_timer = 0;
      end else if (v) begin
         m_timer = 0;
         a = arrow_of(b);
         if (m_pre.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) m_pre.push_back(b);
         end else if (m_pre.size() == 1 && m_pre[0] == 8'hE0) begin
            if (b == 8'hF0) m_pre.push_back(b);
            else if (b != 8'hE0) begin
               if (a >= 0) begin
                  m_held[a] = 1'b1;
                  m_last    = a;
               end
               m_pre.delete();
            end
         end else if (m_pre.size() == 2) begin
            if (a >= 0) m_held[a] = 1'b0;
            m_pre.delete();
         end else begin
            m_pre.delete();
         end
      end else if (m_pre.size() != 0) begin
         m_timer++;
         if (m_timer == TIMEOUT - 1) begin
            m_err = 1'b1;
            m_pre.delete();
            m_timer = 0;
         end
      end
      m_key = 4'b0000;
      if (m_last >= 0 && m_held[m_last]) begin
         m_key[m_last] = 1'b1;
      end else begin
         m_last = -1;
         for (int i = 0; i < 4; i++)
            if (m_last < 0 && m_held[i]) m_last = i;
         if (m_last >= 0) m_key[m_last] = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [7:0] b);
      exp_t e;
      rst      = r;
      rx_valid = v;
      rx_data  = b;
      @(posedge pclk);
      #1;
      model_step(r, v, b);
      if (r || v || m_err) begin
         e.held = m_held;
         e.key  = m_key;
         e.err  = m_err;
         sb.push_back(e);
      end
      rx_valid = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      applyStimulus(1'b0, 1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   always @(posedge pclk) mon_evt <= rst | rx_valid;

   task automatic checkOutput(input string name, input exp_t got, input exp_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got held=%b key=%b err=%b, expected held=%b key=%b err=%b",
                  name, got.held, got.key, got.err, want.held, want.key, want.err);
      end
   endtask

   // Monitor: every reset, byte strobe, or error pulse consumes one expected entry.
   initial begin
      exp_t e;
      exp_t g;
      forever begin
         @(negedge pclk);
         if (mon_evt || parse_err === 1'b1) begin
            g.held = held;
            g.key  = key;
            g.err  = parse_err;
            if (sb.size() == 0) begin
               e = '0;
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_event: got held=%b key=%b err=%b, expected no event",
                        held, key, parse_err);
            end else begin
               e = sb.pop_front();
               checkOutput("response", g, e);
            end
         end
      end
   end

   initial begin
      int pick;
      logic [7:0] b;
      rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      m_held   = 4'b0000;
      m_key    = 4'b0000;
      m_last   = -1;
      m_timer  = 0;
      m_err    = 1'b0;

      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h00);
      idle(2);

      send(8'hE0); send(8'h75);
      idle(1);
      send(8'hE0); send(8'h6B);
      send(8'hE0); send(8'hF0); send(8'h6B);
      idle(2);

      send(8'hE0); send(8'h74);
      send(8'hE0); send(8'h72);
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      idle(1);
      send(8'hE0); send(8'hF0); send(8'h72);
      send(8'hE0); send(8'hF0); send(8'h74);

      send(8'h75);
      send(8'hF0); send(8'h75);
      idle(2);

      send(8'hE0);
      idle(TIMEOUT);
      send(8'h75);
      idle(2);

      send(8'hE0); send(8'h74);
      send(8'hE0); send(8'hF0);
      applyStimulus(1'b1, 1'b0, 8'h00);
      send(8'h6B);
      idle(2);

      for (int n = 0; n < 600; n++) begin
         pick = $urandom_range(0, 9);
         if (pick <= 2)      b = 8'hE0;
         else if (pick == 3) b = 8'hF0;
         else if (pick <= 7) b = arrows[$urandom_range(0, 3)];
         else                b = 8'($urandom);
         if ($urandom_range(0, 99) == 0) applyStimulus(1'b1, 1'b0, 8'h00);
         else send(b);
         idle($urandom_range(0, 2));
      end

      idle(4);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
